pe_row_conv1d: RTL and testbench
================================

// Module: pe_row_conv1d
// PURPOSE
//  Parametrised successor of the fixed 16-wide PE row. Runtime-configurable 1-D convolution row:
//  - loads up to KMAX filter weights, then streams ifmap samples through a sliding window
//  - emits one partial sum per full window, optionally adding an incoming psum from the row above
//  - valid/ready handshakes on every stream, registered multiply/add pipeline, optional saturation
//  Sits between the ifmap/weight buffers and the psum accumulator of the conv engine.
// PARAMETERS
//  DW    8                      data width of weights/samples, signed two's complement
//  KMAX  16                     maximum filter length (window depth)
//  AW    2*DW+$clog2(KMAX)+1    psum width (p_data, o_psum)
//  SAT   0                      0: final add wraps; 1: final add saturates to AW signed range
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  reset: asynchronous, active-high
//  i_start    in   1                  start pulse; sampled in IDLE only
//  i_len      in   $clog2(KMAX+1)     filter length, latched at i_start; 0->1, >KMAX->KMAX
//  i_reuse_w  in   1                  at start: skip LOAD_W, reuse stored weights and len
//  i_psum_en  in   1                  latched at start: add p_data to each output
//  w_valid    in   1 ; w_ready  out 1 ; w_data  in DW   weight stream
//  x_valid    in   1 ; x_ready  out 1 ; x_data  in DW ; x_last in 1   ifmap stream
//  p_data     in   AW                 psum-in, sampled together with each accepted x beat
//  o_valid    out  1 ; o_ready  in 1 ; o_psum  out AW ; o_last out 1  psum stream
//  busy       out  1                  state != IDLE
//  done       out  1                  one-cycle pulse on return to IDLE
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; all outputs 0; weights, window, counters, pipeline cleared.
//  FSM: IDLE -start&!reuse-> LOAD_W; IDLE -start&reuse-> STREAM; LOAD_W -len-th weight-> STREAM;
//       STREAM -x_last accepted-> DRAIN; DRAIN -pipeline empty & last output taken-> IDLE (done=1).
//  i_start outside IDLE ignored. i_reuse_w after reset (no weights loaded) uses zero weights, len=1.
//  LOAD_W: w_ready=1; weights stored w[0..len-1] in arrival order; w[0] pairs with oldest sample.
//  STREAM: x_ready = !stall; stall = o_valid & !o_ready (whole pipeline freezes, no data lost).
//  Window: shift register; sample counter saturates at len. Beat that fills/completes a window
//   (count >= len-1 before accept) issues one output; earlier beats only shift.
//  Pipeline: S1 registers len products w[j]*x[j] (DW x DW -> 2*DW, signed); S2 registers adder
//   tree sum (+ p_data if psum_en). o_valid rises 2 cycles after the issuing x handshake.
//  Arithmetic: products sign-extended to AW; product sum cannot overflow AW; the p_data add
//   wraps (SAT=0) or clamps to [-2^(AW-1), 2^(AW-1)-1] (SAT=1).
//  o_last: set on output issued by the x_last beat. x_last before window filled: no output,
//   o_last never seen, done still pulses once pipeline empty.
//  Output holds o_psum/o_last stable while o_valid & !o_ready.
//  x_last with simultaneous stall: not accepted until stall clears. rst mid-operation aborts,
//   no done pulse, in-flight outputs discarded.
// TESTING
//  1 len=3, w=1,2,3, x=1..5 (x_last on 5), o_ready=1 -> o_psum 14,20,26; o_last on 26; done 1 pulse.
//  2 Same + i_psum_en=1, p_data=100 every beat -> 114,120,126; latency 2 cycles per output.
//  3 Test 1 with o_ready low 5 cycles after first o_valid -> x_ready=0 while stalled, o_psum
//    held at 14, final sequence 14,20,26 unchanged.
//  4 i_reuse_w=1 restart, x=2,2,2,2 -> 12,12 using stored weights; no w_ready assertion.
//  5 len=1, w=-128, x=-128 -> 16384; p_data=1048575, w=1, x=1: SAT=1 -> 1048575,
//    SAT=0 -> -1048576.
//  6 len=3, x=7,8 with x_last on 8 -> no o_valid, done pulses; rst mid-STREAM ->
//    all outputs 0, IDLE, no done.

Source files
------------

// File: rtl/pe_row_conv1d_if.sv
// Stream bundle for the 1-D convolution PE row: weight, ifmap, psum-in and
// psum-out channels. The master side feeds weights/samples and consumes psums.
interface pe_row_conv1d_if #(
  parameter int DW = 8,
  parameter int AW = 21
);
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic          x_last;
  logic [AW-1:0] p_data;
  logic          o_valid;
  logic          o_ready;
  logic [AW-1:0] o_psum;
  logic          o_last;

  modport master (
    output w_valid, w_data, x_valid, x_data, x_last, p_data, o_ready,
    input  w_ready, x_ready, o_valid, o_psum, o_last
  );

  modport slave (
    input  w_valid, w_data, x_valid, x_data, x_last, p_data, o_ready,
    output w_ready, x_ready, o_valid, o_psum, o_last
  );
endinterface

// File: rtl/pe_row_conv1d.sv
// Runtime-configurable 1-D convolution PE row. Loads up to KMAX weights, slides
// a window over the ifmap stream and emits one psum per full window through a
// two-stage (multiply, add) pipeline that freezes while the output is stalled.
module pe_row_conv1d #(
  parameter int DW   = 8,
  parameter int KMAX = 16,
  parameter int AW   = 2*DW + $clog2(KMAX) + 1,
  parameter int SAT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [$clog2(KMAX+1)-1:0] i_len,
  input  logic                      i_reuse_w,
  input  logic                      i_psum_en,
  pe_row_conv1d_if.slave            bus,
  output logic                      busy,
  output logic                      done
);
  localparam int LW = $clog2(KMAX+1);
  localparam int IW = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int PW = 2*DW;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t               state;
  logic [LW-1:0]        len_r;
  logic [LW-1:0]        wcnt;
  logic [LW-1:0]        xcnt;
  logic                 psum_en_r;
  logic [LW-1:0]        len_clamped;

  logic signed [DW-1:0] w_mem   [KMAX];
  logic signed [DW-1:0] win     [KMAX];
  logic signed [DW-1:0] win_n   [KMAX];
  logic signed [PW-1:0] prod_c  [KMAX];
  logic signed [PW-1:0] s1_prod [KMAX];
  logic [IW-1:0]        idx;

  logic                 s1_valid;
  logic                 s1_last;
  logic signed [AW-1:0] s1_p;
  logic signed [AW-1:0] tree_sum;
  logic signed [AW:0]   final_sum;
  logic signed [AW-1:0] result;

  logic stall;
  logic w_fire;
  logic x_fire;
  logic issue;

  assign stall       = bus.o_valid & ~bus.o_ready;
  assign bus.w_ready = (state == LOAD_W);
  assign bus.x_ready = (state == STREAM) & ~stall;
  assign busy        = (state != IDLE);
  assign w_fire      = bus.w_valid & bus.w_ready;
  assign x_fire      = bus.x_valid & bus.x_ready;
  // A beat issues an output once it completes a window of len samples.
  assign issue       = x_fire & (xcnt >= len_r - LW'(1));

  // Clamp the requested filter length into 1..KMAX.
  always_comb begin
    if (i_len == '0)
      len_clamped = LW'(1);
    else if (i_len > LW'(KMAX))
      len_clamped = LW'(KMAX);
    else
      len_clamped = i_len;
  end

  // Window as it will look after the incoming sample shifts in (index 0 newest).
  always_comb begin
    win_n[0] = bus.x_data;
    for (int k = 1; k < KMAX; k++)
      win_n[k] = win[k-1];
  end

  // Products: w[0] pairs with the oldest sample of the len-deep window.
  always_comb begin
    idx = '0;
    for (int j = 0; j < KMAX; j++) begin
      prod_c[j] = '0;
      if (LW'(j) < len_r) begin
        idx       = IW'(len_r - LW'(1) - LW'(j));
        prod_c[j] = w_mem[j] * win_n[idx];
      end
    end
  end

  // Sum sign-extended products, then add psum-in with wrap or saturation.
  always_comb begin
    tree_sum = '0;
    for (int j = 0; j < KMAX; j++)
      tree_sum = tree_sum + {{(AW-PW){s1_prod[j][PW-1]}}, s1_prod[j]};
    final_sum = {tree_sum[AW-1], tree_sum} + {s1_p[AW-1], s1_p};
    if (SAT != 0 && (final_sum[AW] != final_sum[AW-1]))
      result = final_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else
      result = final_sum[AW-1:0];
  end

  // Control FSM: weight loading, sample counting, drain and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_r     <= LW'(1);
      wcnt      <= '0;
      xcnt      <= '0;
      psum_en_r <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < KMAX; k++)
        w_mem[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            psum_en_r <= i_psum_en;
            xcnt      <= '0;
            wcnt      <= '0;
            if (i_reuse_w) begin
              state <= STREAM;
            end else begin
              len_r <= len_clamped;
              state <= LOAD_W;
            end
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            w_mem[IW'(wcnt)] <= bus.w_data;
            wcnt             <= wcnt + LW'(1);
            if (wcnt == len_r - LW'(1))
              state <= STREAM;
          end
        end
        STREAM: begin
          if (x_fire) begin
            if (xcnt < len_r)
              xcnt <= xcnt + LW'(1);
            if (bus.x_last)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid && !stall) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sliding window shift register, advanced on every accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < KMAX; k++)
        win[k] <= '0;
    end else if (x_fire) begin
      for (int k = 0; k < KMAX; k++)
        win[k] <= win_n[k];
    end
  end

  // Multiply and add stages; the whole pipeline holds while the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_p        <= '0;
      bus.o_valid <= 1'b0;
      bus.o_psum  <= '0;
      bus.o_last  <= 1'b0;
      for (int k = 0; k < KMAX; k++)
        s1_prod[k] <= '0;
    end else if (!stall) begin
      s1_valid <= issue;
      s1_last  <= issue & bus.x_last;
      if (issue) begin
        s1_p <= psum_en_r ? bus.p_data : '0;
        for (int k = 0; k < KMAX; k++)
          s1_prod[k] <= prod_c[k];
      end
      bus.o_valid <= s1_valid;
      bus.o_last  <= s1_valid & s1_last;
      if (s1_valid)
        bus.o_psum <= result;
    end
  end
endmodule

// File: tb/tb_pe_row_conv1d.sv
// Self-checking bench for pe_row_conv1d: directed jobs plus randomized jobs,
// compared against a sliding-window dot-product model. Two instances run in
// lockstep, one wrapping and one saturating the final add.
module tb_pe_row_conv1d;
  localparam int DW   = 8;
  localparam int KMAX = 16;
  localparam int AW   = 2*DW + $clog2(KMAX) + 1;
  localparam int LW   = $clog2(KMAX+1);

  logic          clk;
  logic          rst;
  logic          i_start;
  logic [LW-1:0] i_len;
  logic          i_reuse_w;
  logic          i_psum_en;
  logic          busy;
  logic          done;
  logic          busy_s;
  logic          done_s;

  pe_row_conv1d_if #(.DW(DW), .AW(AW)) bus0 ();
  pe_row_conv1d_if #(.DW(DW), .AW(AW)) bus1 ();

  assign bus1.w_valid = bus0.w_valid;
  assign bus1.w_data  = bus0.w_data;
  assign bus1.x_valid = bus0.x_valid;
  assign bus1.x_data  = bus0.x_data;
  assign bus1.x_last  = bus0.x_last;
  assign bus1.p_data  = bus0.p_data;
  assign bus1.o_ready = bus0.o_ready;

  pe_row_conv1d #(.DW(DW), .KMAX(KMAX), .AW(AW), .SAT(0)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_reuse_w(i_reuse_w), .i_psum_en(i_psum_en), .bus(bus0),
    .busy(busy), .done(done)
  );

  pe_row_conv1d #(.DW(DW), .KMAX(KMAX), .AW(AW), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_reuse_w(i_reuse_w), .i_psum_en(i_psum_en), .bus(bus1),
    .busy(busy_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint wq[$];
  longint xq[$];
  longint pq[$];
  longint m_w[KMAX];
  int     m_len;

  function automatic longint wrap_aw(input longint v);
    longint m;
    longint r;
    m = longint'(1) << AW;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m/2) r -= m;
    return r;
  endfunction

  function automatic longint sat_aw(input longint v);
    longint hi;
    longint lo;
    hi = (longint'(1) << (AW-1)) - 1;
    lo = -(longint'(1) << (AW-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check_output(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_start      = 1'b0;
    bus0.w_valid = 1'b0;
    bus0.x_valid = 1'b0;
    bus0.x_last  = 1'b0;
    bus0.o_ready = 1'b1;
  endtask

  // One job: start, load weights (unless reuse), stream xq/pq, collect psums.
  task automatic apply_stimulus(input string tag, input int len_in, input bit reuse,
                                input bit psum_en, input bit stall5, input bit rnd_flow,
                                input bit check_lat, input int abort_xi);
    longint exp_wrap[$];
    longint exp_sat[$];
    bit     exp_last[$];
    int     iss_q[$];
    int     nx, wi, xi, oi, stall_left, done_cnt, wr_cnt;
    longint acc;
    nx = xq.size();
    if (!reuse) begin
      m_len = (len_in == 0) ? 1 : ((len_in > KMAX) ? KMAX : len_in);
      for (int j = 0; j < m_len; j++) m_w[j] = wq[j];
    end
    for (int n = m_len - 1; n < nx; n++) begin
      acc = psum_en ? pq[n] : 0;
      for (int j = 0; j < m_len; j++) acc += m_w[j] * xq[n - m_len + 1 + j];
      exp_wrap.push_back(wrap_aw(acc));
      exp_sat.push_back(sat_aw(acc));
      exp_last.push_back(n == nx - 1);
    end
    wi = 0; xi = 0; oi = 0; stall_left = -1; done_cnt = 0; wr_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (bus0.w_ready) wr_cnt++;
      if (done_cnt > 0) break;
      if (stall5 && bus0.o_valid && stall_left < 0) stall_left = 5;
      if (stall_left > 0) begin
        bus0.o_ready = 1'b0;
        stall_left--;
      end else if (rnd_flow) bus0.o_ready = ($urandom_range(0, 3) != 0);
      else bus0.o_ready = 1'b1;
      i_start   = (cyc == 0);
      i_len     = LW'(len_in);
      i_reuse_w = reuse;
      i_psum_en = psum_en;
      if (!reuse && wi < m_len && (!rnd_flow || $urandom_range(0, 1) == 1)) begin
        bus0.w_valid = 1'b1;
        bus0.w_data  = DW'(wq[wi]);
      end else begin
        bus0.w_valid = 1'b0;
        bus0.w_data  = DW'($urandom);
      end
      if (xi < nx && (!rnd_flow || $urandom_range(0, 2) != 0)) begin
        bus0.x_valid = 1'b1;
        bus0.x_data  = DW'(xq[xi]);
        bus0.x_last  = (xi == nx - 1);
        bus0.p_data  = AW'(pq[xi]);
      end else begin
        bus0.x_valid = 1'b0;
        bus0.x_data  = DW'($urandom);
        bus0.x_last  = 1'b0;
        bus0.p_data  = AW'($urandom);
      end
      #1;
      if (bus0.w_valid && bus0.w_ready) wi++;
      if (bus0.x_valid && bus0.x_ready) begin
        if (xi >= m_len - 1) iss_q.push_back(cyc);
        xi++;
      end
      if (bus0.o_valid && !bus0.o_ready) begin
        check_output({tag, " x_ready_in_stall"}, bus0.x_ready, 0);
        if (oi < exp_wrap.size())
          check_output({tag, " held_psum"}, $signed(bus0.o_psum), exp_wrap[oi]);
      end
      if (bus0.o_valid && bus0.o_ready) begin
        if (oi < exp_wrap.size()) begin
          check_output($sformatf("%s psum[%0d]", tag, oi), $signed(bus0.o_psum), exp_wrap[oi]);
          check_output($sformatf("%s sat_psum[%0d]", tag, oi), $signed(bus1.o_psum), exp_sat[oi]);
          check_output($sformatf("%s last[%0d]", tag, oi), bus0.o_last, exp_last[oi]);
          if (check_lat && oi < iss_q.size())
            check_output($sformatf("%s latency[%0d]", tag, oi), cyc, iss_q[oi] + 2);
        end else begin
          check_output({tag, " unexpected_output"}, 1, (oi < exp_wrap.size()) ? 1 : 0);
        end
        oi++;
      end
      if (abort_xi >= 0 && xi >= abort_xi) return;
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_output({tag, " done_pulses"}, done_cnt, 1);
    check_output({tag, " output_count"}, oi, exp_wrap.size());
    check_output({tag, " idle_busy"}, busy, 0);
    check_output({tag, " idle_o_valid"}, bus0.o_valid, 0);
    if (reuse) check_output({tag, " w_ready_seen"}, wr_cnt, 0);
  endtask

  initial begin
    int     len_in;
    int     nx;
    int     dcnt;
    bit     reuse;
    bit     pen;
    longint pv;

    rst = 1'b1;
    i_len = '0; i_reuse_w = 1'b0; i_psum_en = 1'b0;
    bus0.w_data = '0; bus0.x_data = '0; bus0.p_data = '0;
    idle_inputs();
    for (int j = 0; j < KMAX; j++) m_w[j] = 0;
    m_len = 1;
    @(negedge clk);
    @(negedge clk);
    check_output("reset o_valid", bus0.o_valid, 0);
    check_output("reset o_psum", bus0.o_psum, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset w_ready", bus0.w_ready, 0);
    check_output("reset x_ready", bus0.x_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic window, len=3");
    wq = '{1, 2, 3}; xq = '{1, 2, 3, 4, 5}; pq = '{55, -9, 300, 7, 1};
    apply_stimulus("t1", 3, 0, 0, 0, 0, 1, -1);

    $display("[TB] psum-in add");
    pq = '{100, 100, 100, 100, 100};
    apply_stimulus("t2", 3, 0, 1, 0, 0, 1, -1);

    $display("[TB] output stall");
    apply_stimulus("t3", 3, 0, 0, 1, 0, 0, -1);

    $display("[TB] weight reuse");
    xq = '{2, 2, 2, 2}; pq = '{0, 0, 0, 0};
    apply_stimulus("t4", 9, 1, 0, 0, 0, 1, -1);

    $display("[TB] extreme products and final add overflow");
    wq = '{-128}; xq = '{-128}; pq = '{0};
    apply_stimulus("t5a", 1, 0, 0, 0, 0, 1, -1);
    wq = '{1}; xq = '{1}; pq = '{1048575};
    apply_stimulus("t5b", 1, 0, 1, 0, 0, 1, -1);

    $display("[TB] length clamping");
    wq = '{5}; xq = '{1, 2, 3}; pq = '{0, 0, 0};
    apply_stimulus("len0", 0, 0, 0, 0, 0, 1, -1);
    wq.delete(); xq.delete(); pq.delete();
    for (int j = 0; j < KMAX; j++) wq.push_back(longint'($urandom_range(0, 255)) - 128);
    for (int j = 0; j < 18; j++) begin
      xq.push_back(longint'($urandom_range(0, 255)) - 128);
      pq.push_back(0);
    end
    apply_stimulus("len20", 20, 0, 0, 0, 0, 1, -1);

    $display("[TB] x_last before window filled");
    wq = '{1, 1, 1}; xq = '{7, 8}; pq = '{0, 0};
    apply_stimulus("t6a", 3, 0, 0, 0, 0, 0, -1);

    $display("[TB] reset during streaming");
    xq = '{1, 2, 3, 4, 5, 6}; pq = '{0, 0, 0, 0, 0, 0};
    apply_stimulus("t6b", 3, 0, 0, 0, 0, 0, 4);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check_output("abort o_valid", bus0.o_valid, 0);
    check_output("abort o_psum", bus0.o_psum, 0);
    check_output("abort o_last", bus0.o_last, 0);
    check_output("abort busy", busy, 0);
    check_output("abort done", done, 0);
    check_output("abort x_ready", bus0.x_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < KMAX; j++) m_w[j] = 0;
    m_len = 1;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || bus0.o_valid) dcnt++;
    end
    check_output("abort no_done_no_output", dcnt, 0);

    $display("[TB] reuse after reset: zero weights, len 1");
    xq = '{5, 6}; pq = '{-7, 300000};
    apply_stimulus("zero_w", 4, 1, 1, 0, 0, 1, -1);

    $display("[TB] randomized jobs");
    for (int r = 0; r < 8; r++) begin
      len_in = $urandom_range(0, 20);
      reuse  = (r % 3 == 2);
      pen    = ($urandom_range(0, 1) == 1);
      nx     = $urandom_range(1, 24);
      wq.delete(); xq.delete(); pq.delete();
      for (int j = 0; j < KMAX; j++) wq.push_back(longint'($urandom_range(0, 255)) - 128);
      for (int j = 0; j < nx; j++) begin
        xq.push_back(longint'($urandom_range(0, 255)) - 128);
        case ($urandom_range(0, 7))
          0:       pv = 1048575 - longint'($urandom_range(0, 100));
          1:       pv = -1048576 + longint'($urandom_range(0, 100));
          default: pv = longint'($urandom_range(0, 2000)) - 1000;
        endcase
        pq.push_back(pv);
      end
      apply_stimulus($sformatf("rnd%0d", r), len_in, reuse, pen, 0, 1, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
